// File: rtl/adain_seq_pkg.sv
// Shared constants, state encoding and lane-count helper for the ADAIN lane sequencer.
package adain_seq_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } seq_state_e;

  // A lane count of 0 or anything above 8 means "all eight lanes".
  function automatic logic [3:0] eff_lanes(input logic [3:0] num);
    return ((num == 4'd0) || (num > 4'd8)) ? 4'd8 : num;
  endfunction

endpackage

// File: rtl/adain_lane_sequencer_mux_8to1.sv
// Eight-way lane word selector used to form the sequencer output word.
module mux_8to1
  import adain_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [LANES*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]       sel,
  output logic [WIDTH-1:0]       dout
);

  assign dout = din[sel*WIDTH +: WIDTH];

endmodule

// File: rtl/adain_lane_sequencer.sv
// Serialises an 8-lane group into per-lane beats; optional one-group prefetch
// is enabled by defining ADAIN_SEQ_PREFETCH_EN.
//
// state  | meaning
// S_IDLE | no active group; ready to capture one
// S_SEND | emitting lanes 0..N-1 of the active group
module adain_lane_sequencer
  import adain_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [3:0]             num_lanes,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]       out_lane,
  output logic                   out_last
);

  seq_state_e             state;
  logic [LANES*WIDTH-1:0] act_data;
  logic [3:0]             act_n;
  logic [3:0]             in_n;
  logic                   acc;
  logic                   beat;
  logic                   last_beat;

`ifdef ADAIN_SEQ_PREFETCH_EN
  logic                   pf_valid;
  logic [LANES*WIDTH-1:0] pf_data;
  logic [3:0]             pf_n;
`endif

  assign acc       = in_valid & in_ready;
  assign beat      = out_valid & out_ready;
  assign last_beat = beat & out_last;
  assign in_n      = eff_lanes(num_lanes);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      act_data  <= '0;
      act_n     <= '0;
      out_valid <= 1'b0;
      out_lane  <= '0;
      out_last  <= 1'b0;
      in_ready  <= 1'b0;
`ifdef ADAIN_SEQ_PREFETCH_EN
      pf_valid  <= 1'b0;
      pf_data   <= '0;
      pf_n      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (acc) begin
            state     <= S_SEND;
            act_data  <= in_data;
            act_n     <= in_n;
            out_valid <= 1'b1;
            out_lane  <= '0;
            out_last  <= (in_n == 4'd1);
`ifdef ADAIN_SEQ_PREFETCH_EN
            in_ready  <= 1'b1;
`else
            in_ready  <= 1'b0;
`endif
          end else begin
            in_ready  <= 1'b1;
          end
        end
        S_SEND: begin
          if (last_beat) begin
`ifdef ADAIN_SEQ_PREFETCH_EN
            // Zero-bubble hand-over: the next group becomes active on the same edge.
            if (pf_valid) begin
              act_data <= pf_data;
              act_n    <= pf_n;
              out_lane <= '0;
              out_last <= (pf_n == 4'd1);
              pf_valid <= 1'b0;
              pf_data  <= '0;
              pf_n     <= '0;
              in_ready <= 1'b1;
            end else if (acc) begin
              act_data <= in_data;
              act_n    <= in_n;
              out_lane <= '0;
              out_last <= (in_n == 4'd1);
              in_ready <= 1'b1;
            end else begin
              state     <= S_IDLE;
              out_valid <= 1'b0;
              out_lane  <= '0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
            end
`else
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_lane  <= '0;
            out_last  <= 1'b0;
            in_ready  <= 1'b1;
`endif
          end else begin
            if (beat) begin
              out_lane <= out_lane + 3'd1;
              out_last <= (({1'b0, out_lane} + 4'd2) == act_n);
            end
`ifdef ADAIN_SEQ_PREFETCH_EN
            if (acc) begin
              pf_valid <= 1'b1;
              pf_data  <= in_data;
              pf_n     <= in_n;
              in_ready <= 1'b0;
            end
`endif
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          out_lane  <= '0;
          out_last  <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

  mux_8to1 #(.WIDTH(WIDTH)) u_mux (
    .din  (act_data),
    .sel  (out_lane),
    .dout (out_data)
  );

endmodule

// File: tb/tb_adain_lane_sequencer.sv
// Directed self-checking bench for adain_lane_sequencer (default and prefetch builds).
module tb_adain_lane_sequencer;
  localparam int WIDTH = 16;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [8*WIDTH-1:0] in_data;
  logic [3:0]        num_lanes;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [2:0]        out_lane;
  logic              out_last;

  int tests;
  int fails;

  adain_lane_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .num_lanes (num_lanes),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8*WIDTH-1:0] pack(input logic [WIDTH-1:0] base);
    logic [8*WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[k*WIDTH +: WIDTH] = base + WIDTH'(k);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_group(input logic [WIDTH-1:0] base, input logic [3:0] num);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_wait_ready: in_ready=%b required 1 after %0d cycles", in_ready, n);
    end
    in_valid  = 1'b1;
    in_data   = pack(base);
    num_lanes = num;
    step();
    in_valid  = 1'b0;
    in_data   = '1;
    num_lanes = 4'd5;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; num_lanes = 4'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    tests++; if (out_lane !== 3'd0) begin fails++; $display("FAIL rst_out_lane: got %0d want 0", out_lane); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    tests++; if (out_data !== 16'h0) begin fails++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
    #2 rst_n = 1'b1;
    step();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_release_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_full8();
    out_ready = 1'b1;
    send_group(16'h0000, 4'd8);
    for (int i = 0; i < 8; i++) begin
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL full8_valid[%0d]: got %b want 1", i, out_valid); end
      tests++; if (out_data !== 16'(i)) begin fails++; $display("FAIL full8_data[%0d]: got %h want %h", i, out_data, 16'(i)); end
      tests++; if (out_lane !== 3'(i)) begin fails++; $display("FAIL full8_lane[%0d]: got %0d want %0d", i, out_lane, i); end
      tests++; if (out_last !== (i == 7)) begin fails++; $display("FAIL full8_last[%0d]: got %b want %b", i, out_last, (i == 7)); end
      step();
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full8_end_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_lane_counts();
    out_ready = 1'b1;
    send_group(16'h0010, 4'd3);
    for (int i = 0; i < 3; i++) begin
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL n3_valid[%0d]: got %b want 1", i, out_valid); end
      tests++; if (out_data !== 16'(16'h10 + i)) begin fails++; $display("FAIL n3_data[%0d]: got %h want %h", i, out_data, 16'(16'h10 + i)); end
      tests++; if (out_last !== (i == 2)) begin fails++; $display("FAIL n3_last[%0d]: got %b want %b", i, out_last, (i == 2)); end
      step();
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL n3_end_valid: got %b want 0", out_valid); end

    send_group(16'h0100, 4'd0);
    for (int i = 0; i < 8; i++) begin
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL n0_valid[%0d]: got %b want 1", i, out_valid); end
      tests++; if (out_data !== 16'(16'h100 + i)) begin fails++; $display("FAIL n0_data[%0d]: got %h want %h", i, out_data, 16'(16'h100 + i)); end
      tests++; if (out_last !== (i == 7)) begin fails++; $display("FAIL n0_last[%0d]: got %b want %b", i, out_last, (i == 7)); end
      step();
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL n0_end_valid: got %b want 0", out_valid); end

    send_group(16'h0200, 4'd1);
    tests++; if (out_valid !== 1'b1 || out_data !== 16'h0200 || out_last !== 1'b1)
      begin fails++; $display("FAIL n1_beat: got v=%b d=%h l=%b want v=1 d=0200 l=1", out_valid, out_data, out_last); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL n1_end_valid: got %b want 0", out_valid); end

    send_group(16'h0300, 4'd12);
    for (int i = 0; i < 8; i++) begin
      tests++; if (out_data !== 16'(16'h300 + i) || out_last !== (i == 7))
        begin fails++; $display("FAIL n12_beat[%0d]: got d=%h l=%b want d=%h l=%b", i, out_data, out_last, 16'(16'h300 + i), (i == 7)); end
      step();
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL n12_end_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    send_group(16'h0020, 4'd8);
    tests++; if (out_lane !== 3'd0 || out_data !== 16'h0020) begin fails++; $display("FAIL stall_lane0: got lane=%0d d=%h want 0/0020", out_lane, out_data); end
    step();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tests++; if (out_valid !== 1'b1 || out_lane !== 3'd1 || out_data !== 16'h0021 || out_last !== 1'b0)
        begin fails++; $display("FAIL stall_hold[%0d]: got v=%b lane=%0d d=%h l=%b want 1/1/0021/0", s, out_valid, out_lane, out_data, out_last); end
      if (s < 2) step();
    end
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tests++; if (out_lane !== 3'(i) || out_data !== 16'(16'h20 + i) || out_last !== (i == 7))
        begin fails++; $display("FAIL stall_resume[%0d]: got lane=%0d d=%h l=%b want %0d/%h/%b", i, out_lane, out_data, out_last, i, 16'(16'h20 + i), (i == 7)); end
      step();
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_end_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int gap;
    logic acc;
    logic exp_v;
    logic [WIDTH-1:0] exp_d;
`ifdef ADAIN_SEQ_PREFETCH_EN
    gap = 0;
`else
    gap = 1;
`endif
    out_ready = 1'b1;
    send_group(16'h0030, 4'd8);
    in_valid  = 1'b1;
    in_data   = pack(16'h0040);
    num_lanes = 4'd8;
    for (int idx = 0; idx < 18; idx++) begin
      exp_v = (idx < 8) || (idx >= 8 + gap && idx < 16 + gap);
      exp_d = (idx < 8) ? WIDTH'(16'h30 + idx) : WIDTH'(16'h40 + idx - 8 - gap);
      tests++; if (out_valid !== exp_v) begin fails++; $display("FAIL b2b_valid[%0d]: got %b want %b", idx, out_valid, exp_v); end
      if (exp_v) begin
        tests++; if (out_data !== exp_d) begin fails++; $display("FAIL b2b_data[%0d]: got %h want %h", idx, out_data, exp_d); end
      end
      acc = in_valid & in_ready;
      step();
      if (acc) begin
        in_valid = 1'b0;
        in_data  = '1;
      end
    end
    tests++; if (in_valid !== 1'b0) begin fails++; $display("FAIL b2b_group_b_accepted: in_valid=%b want 0", in_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send_group(16'h0050, 4'd8);
    for (int i = 0; i < 4; i++) step();
    tests++; if (out_lane !== 3'd4 || out_data !== 16'h0054) begin fails++; $display("FAIL midrst_at_lane4: got lane=%0d d=%h want 4/0054", out_lane, out_data); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid_immediate: got %b want 0", out_valid); end
    tests++; if (out_lane !== 3'd0 || in_ready !== 1'b0) begin fails++; $display("FAIL midrst_regs: got lane=%0d rdy=%b want 0/0", out_lane, in_ready); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_release_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_no_beats[%0d]: got %b want 0", i, out_valid); end
      step();
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_full8();
    test_lane_counts();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
